// File: rtl/adder_digit.sv
// One digit of the serial adder: DIGIT chained 1-bit full-adder cells.
// Also exposes the carry into the MSB cell so the caller can derive signed overflow.
module adder_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             c_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[DIGIT];
    assign cmsb_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock,
// carry held in a register between digits, valid/ready on both sides.
module serial_digit_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             incarry,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             outcarry,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    if ((WIDTH % DIGIT) != 0) begin : g_bad_cfg
        $error("serial_digit_adder: WIDTH must be a multiple of DIGIT");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              c_q, c_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              outcarry_q, outcarry_d;
    logic              overflow_q, overflow_d;
    logic              out_valid_q, out_valid_d;

    logic              accept;
    logic              last_digit;
    logic [DIGIT-1:0]  a_dig, b_dig, dig_sum;
    logic              dig_cout, dig_cmsb;

    assign accept     = in_valid & in_ready;
    assign last_digit = (cnt_q == CW'(NDIG - 1));
    assign a_dig      = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign b_dig      = b_q[int'(cnt_q) * DIGIT +: DIGIT];

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a_i    (a_dig),
        .b_i    (b_dig),
        .c_i    (c_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout),
        .cmsb_o (dig_cmsb)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State decode; out_ready -> in_ready is combinational so DONE can hand straight over to RUN
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            RUN:     busy     = 1'b1;
            DONE:    in_ready = out_ready;
            default: ;
        endcase
    end

    // Datapath next values: operand capture on accept, one digit per RUN cycle
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        outcarry_d  = outcarry_q;
        overflow_d  = overflow_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            a_d         = a;
            b_d         = sub ? ~b : b;
            c_d         = incarry ^ sub;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else if (state_q == RUN) begin
            sum_d[int'(cnt_q) * DIGIT +: DIGIT] = dig_sum;
            c_d   = dig_cout;
            cnt_d = cnt_q + CW'(1);
            if (last_digit) begin
                outcarry_d  = dig_cout;
                overflow_d  = dig_cmsb ^ dig_cout;
                out_valid_d = 1'b1;
            end
        end else if ((state_q == DONE) && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            outcarry_q  <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            outcarry_q  <= outcarry_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign outcarry  = outcarry_q;
    assign overflow  = overflow_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed bench for serial_digit_adder across four configurations:
// (8,2), (1,1), (16,16) and (16,4), sharing operand buses with per-instance handshakes.
module tb_serial_digit_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [3:0]  out_ready;
    logic [15:0] a, b;
    logic        incarry, sub;

    logic [3:0]  in_ready, out_valid, outcarry, overflow, busy;
    logic [7:0]  sum8;
    logic [0:0]  sum1;
    logic [15:0] sum16a, sum16b;
    logic [3:0][15:0] sumx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sumx[0] = {8'h00, sum8};
    assign sumx[1] = {15'h0000, sum1};
    assign sumx[2] = sum16a;
    assign sumx[3] = sum16b;

    serial_digit_adder #(.WIDTH(8), .DIGIT(2)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[7:0]), .b(b[7:0]), .incarry(incarry), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .sum(sum8),
        .outcarry(outcarry[0]), .overflow(overflow[0]), .busy(busy[0]));

    serial_digit_adder #(.WIDTH(1), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[0:0]), .b(b[0:0]), .incarry(incarry), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .sum(sum1),
        .outcarry(outcarry[1]), .overflow(overflow[1]), .busy(busy[1]));

    serial_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .incarry(incarry), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .sum(sum16a),
        .outcarry(outcarry[2]), .overflow(overflow[2]), .busy(busy[2]));

    serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d16d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a), .b(b), .incarry(incarry), .sub(sub),
        .out_valid(out_valid[3]), .out_ready(out_ready[3]), .sum(sum16b),
        .outcarry(outcarry[3]), .overflow(overflow[3]), .busy(busy[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {ov, carry, sum} for a w-bit add of a + (sub?~b:b) + (cin^sub)
    function automatic logic [17:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic cin, input logic s);
        logic [16:0] mask, full;
        logic [15:0] am, beff, sm;
        logic        c, ov;
        mask = (17'(1) << w) - 17'(1);
        am   = av & mask[15:0];
        beff = (s ? ~bv : bv) & mask[15:0];
        full = 17'(am) + 17'(beff) + 17'(cin ^ s);
        c    = full[w];
        sm   = full[15:0] & mask[15:0];
        ov   = (am[w-1] == beff[w-1]) && (sm[w-1] != am[w-1]);
        return {ov, c, sm};
    endfunction

    task automatic wait_result(input int idx, output int lat);
        lat = 0;
        while (!out_valid[idx] && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Present operands, hold until accepted, then scramble inputs and time the result
    task automatic issue(input int idx, input logic [15:0] av, input logic [15:0] bv,
                         input logic cin, input logic s, output int lat);
        int n;
        @(negedge clk);
        a = av; b = bv; incarry = cin; sub = s;
        in_valid[idx] = 1'b1;
        #1;
        n = 0;
        while (!in_ready[idx] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); incarry = ~cin; sub = ~s;
        wait_result(idx, lat);
    endtask

    task automatic check_result(input int idx, input string tag, input logic [15:0] es,
                                input logic ec, input logic eov, input int elat, input int lat);
        check({tag, "_valid"}, 32'(out_valid[idx]), 32'd1);
        check({tag, "_sum"}, 32'(sumx[idx]), 32'(es));
        check({tag, "_carry"}, 32'(outcarry[idx]), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow[idx]), 32'(eov));
        check({tag, "_lat"}, 32'(lat), 32'(elat));
    endtask

    task automatic op(input int idx, input string tag, input logic [15:0] av, input logic [15:0] bv,
                      input logic cin, input logic s, input logic [15:0] es, input logic ec,
                      input logic eov, input int elat);
        int lat;
        issue(idx, av, bv, cin, s, lat);
        check_result(idx, tag, es, ec, eov, elat, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0]  st_sum, st_co, st_ov;
        logic [2:0]  combo;
        logic [17:0] exp;
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          lat;

        rst_n = 1'b0; in_valid = '0; out_ready = 4'hF;
        a = '0; b = '0; incarry = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum8), 32'h0);
        check("rst_valid", 32'(out_valid[0]), 32'd0);
        check("rst_carry", 32'(outcarry[0]), 32'd0);
        check("rst_ovf", 32'(overflow[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add / subtract on the (8,2) instance
        op(0, "t1_add", 16'h5A, 16'h3C, 1'b0, 1'b0, 16'h96, 1'b0, 1'b1, 4);
        op(0, "t2_wrap", 16'hFF, 16'h01, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 4);
        op(0, "t2_sub", 16'h10, 16'h20, 1'b0, 1'b1, 16'hF0, 1'b0, 1'b0, 4);

        // Backpressure then back-to-back handover
        out_ready[0] = 1'b0;
        issue(0, 16'h7F, 16'h01, 1'b0, 1'b0, lat);
        check_result(0, "t3_first", 16'h80, 1'b0, 1'b1, 4, lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", 32'(out_valid[0]), 32'd1);
            check("t3_hold_sum", 32'(sum8), 32'h80);
            check("t3_hold_flags", {30'd0, outcarry[0], overflow[0]}, 32'h1);
            check("t3_hold_in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(negedge clk);
        a = 16'h80; b = 16'h01; incarry = 1'b0; sub = 1'b1;
        in_valid[0] = 1'b1; out_ready[0] = 1'b1;
        #1;
        check("t3_b2b_in_ready", 32'(in_ready[0]), 32'd1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0; a = 16'h0; b = 16'h0; sub = 1'b0;
        check("t3_b2b_valid_drop", 32'(out_valid[0]), 32'd0);
        check("t3_b2b_busy", 32'(busy[0]), 32'd1);
        wait_result(0, lat);
        check_result(0, "t3_second", 16'h7F, 1'b1, 1'b1, 4, lat);
        @(posedge clk); #1;

        // Reset during digit 2
        @(negedge clk);
        a = 16'hFF; b = 16'hFF; incarry = 1'b1; sub = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        check("t4_busy", 32'(busy[0]), 32'd1);
        check("t4_in_ready_busy", 32'(in_ready[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t4_rst_sum", 32'(sum8), 32'h0);
        check("t4_rst_valid", 32'(out_valid[0]), 32'd0);
        check("t4_rst_busy", 32'(busy[0]), 32'd0);
        check("t4_rst_flags", {30'd0, outcarry[0], overflow[0]}, 32'h0);
        check("t4_rst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        op(0, "t4_fresh", 16'h01, 16'h02, 1'b0, 1'b0, 16'h03, 1'b0, 1'b0, 4);

        // 1-bit full-adder truth table, index = {a,b,cin}
        st_sum = 8'b1001_0110;
        st_co  = 8'b1110_1000;
        st_ov  = 8'b0100_0010;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            op(1, "t5_fa", {15'd0, combo[2]}, {15'd0, combo[1]}, combo[0], 1'b0,
               {15'd0, st_sum[i]}, st_co[i], st_ov[i], 1);
        end

        // Single-digit 16-bit
        op(2, "t6_w16_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        op(2, "t6_w16_sub", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1);

        // Random operands on the 4-digit 16-bit instance
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom); rs = 1'($urandom);
            exp = model(16, ra, rb, rc, rs);
            op(3, "t6_rand", ra, rb, rc, rs, exp[15:0], exp[16], exp[17], 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_digit_adder.md
Name: serial_digit_adder

Overview:
Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock through a ripple chain of 1-bit full-adder cells, and holds the carry in a register between digits. It is the sequential, width-generalised successor of the team's 1-bit full-adder cell, for arithmetic datapaths where area matters more than latency. Input and output use valid/ready handshakes.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits added per clock (1..WIDTH).
NDIG, WIDTH/DIGIT, derived local constant: number of digit cycles.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand set offered.
in_ready  output  1  block can accept operands this cycle.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
incarry  input  1  carry-in; acts as borrow-in when sub=1.
sub  input  1  0: a+b+incarry; 1: a-b-incarry.
out_valid  output  1  result registers hold a valid result.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result.
outcarry  output  1  carry-out; for subtraction, 1 = no borrow.
overflow  output  1  two's-complement signed overflow.
busy  output  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release): state=IDLE; sum=0, outcarry=0, overflow=0, out_valid=0, busy=0; all internal operand, carry and counter registers cleared. Asserting reset mid-operation aborts the operation; nothing is emitted.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). The comb path from out_ready to in_ready is intentional and allows back-to-back operation.
- Accept on the edge where in_valid & in_ready:
  - Latch a.
  - Latch b_eff = sub ? ~b : b.
  - Carry register c = incarry ^ sub.
  - Digit counter = 0; state -> RUN.
- RUN, one digit per cycle:
  - Digit i uses bits [i*DIGIT +: DIGIT].
  - The digit sum is written into sum[i*DIGIT +: DIGIT].
  - The digit carry-out is stored into c.
  - The carry into the MSB cell of the final digit is captured for overflow.
- After digit NDIG-1: outcarry = c; overflow = carry into MSB ^ carry out of MSB; out_valid=1; state -> DONE.
- Latency: out_valid rises exactly NDIG cycles after the accept edge. DIGIT==WIDTH gives 1 cycle.
- sum is not required to be stable during RUN. It is stable whenever out_valid=1.
- DONE:
  - out_valid, sum, outcarry and overflow hold until out_ready.
  - On out_ready & ~in_valid: out_valid=0, state -> IDLE.
  - On out_ready & in_valid: out_valid=0, the new operands are accepted in the same cycle, state -> RUN.
- in_valid while busy is ignored (in_ready=0). Input signals are sampled only on the accept edge; later changes have no effect.
- WIDTH % DIGIT != 0 is an elaboration error (generate-time check).

Decomposition:
- No package needed.
- The NDIG constant and state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) are local to the module.
- Sub-module adder_digit (parameter DIGIT) is combinational. It chains DIGIT 1-bit full-adder cells and outputs the digit sum, carry-out and carry into its MSB cell.

Test Plan:
1. WIDTH=8, DIGIT=2; a=0x5A, b=0x3C, incarry=0, sub=0 -> sum=0x96, outcarry=0, overflow=1; out_valid exactly 4 cycles after accept.
2. a=0xFF, b=0x01, incarry=0, sub=0 -> sum=0x00, outcarry=1, overflow=0. Then a=0x10, b=0x20, sub=1, incarry=0 -> sum=0xF0, outcarry=0 (borrow), overflow=0.
3. Backpressure: hold out_ready=0 for 10 cycles after the result -> out_valid, sum and flags stay constant and in_ready=0. Raise out_ready together with in_valid -> the next operand is accepted in the same cycle, and its result arrives 4 cycles later.
4. Reset mid-RUN: assert rst_n=0 during digit 2 -> outputs zero immediately and state IDLE. After release, a fresh operation completes correctly with no stale carry.
5. WIDTH=1, DIGIT=1 -> all 8 {a,b,incarry} combos with sub=0 match the 1-bit full-adder truth table; latency 1 cycle.
6. WIDTH=16, DIGIT=16, plus 1000 random operands with WIDTH=16, DIGIT=4 -> results match a reference model of {outcarry,sum} = a + (sub?~b:b) + (incarry^sub), with overflow per signed rule. Latencies are 1 and 4 cycles respectively.
